// File: rtl/tm1638_pkg.sv
// Shared TM1638 constants and types for the key reader (and the display writer,
// which reuses the command constants and the SCLK phase generator).
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam int KEY_BYTES = 4;
  localparam int KEY_BITS  = 8;
  localparam int RX_BITS   = KEY_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } tm1638_rd_state_t;

  // Key Si lives in bit 0 (S1..S4) or bit 4 (S5..S8) of read byte (i-1)%4.
  function automatic logic [KEY_BITS-1:0] keys_from_rx(input logic [RX_BITS-1:0] rx);
    logic [KEY_BITS-1:0] k;
    k = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      k[b]     = rx[8*b];
      k[b + 4] = rx[8*b + 4];
    end
    return k;
  endfunction

  // Lowest pressed key wins; 0 means nothing pressed.
  function automatic logic [3:0] key_code_f(input logic [KEY_BITS-1:0] k);
    logic [3:0] code;
    code = 4'd0;
    for (int i = KEY_BITS - 1; i >= 0; i--) begin
      if (k[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/tm1638_key_reader_if.sv
// Bundles the user handshake and the TM1638 pin signals of the key reader.
interface tm1638_key_reader_if;
  import tm1638_pkg::*;

  // start is sampled only while idle; busy is high from the cycle after an
  // accepted start through the done cycle; done pulses for one cycle with
  // keys/key_code updated in that same cycle.
  logic                start;
  logic                busy;
  logic                done;
  logic [KEY_BITS-1:0] keys;
  logic [3:0]          key_code;
  logic                stb;
  logic                sclk;
  logic                dio_o;
  logic                dio_oe;
  logic                dio_i;

  modport master (
    output start, dio_i,
    input  busy, done, keys, key_code, stb, sclk, dio_o, dio_oe
  );

  modport slave (
    input  start, dio_i,
    output busy, done, keys, key_code, stb, sclk, dio_o, dio_oe
  );

endinterface

// File: rtl/tm1638_sclk_gen.sv
// SCLK half-period counter: strobes ph_end on the last cycle of each phase and
// flips phase_hi there. clr restarts it in a high phase (the STB setup time).
module tm1638_sclk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ph_end,
  output logic phase_hi
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    ph_end  = en && (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (ph_end) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_hi = phase_q;

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read-keys command, reads 4 bytes LSB first
// and reduces them to an 8-bit pressed mask plus a priority-encoded key number.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  tm1638_key_reader_if.slave   bus,
  output tm1638_rd_state_t     dbg_state
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [4:0]    CMD_LAST  = 5'd7;
  localparam logic [4:0]    RX_LAST   = 5'(RX_BITS - 1);

  tm1638_rd_state_t    state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                stb_q, stb_d, sclk_q, sclk_d;
  logic                dio_o_q, dio_o_d, dio_oe_q, dio_oe_d;
  logic [KEY_BITS-1:0] keys_q, keys_d;
  logic [3:0]          key_code_q, key_code_d;
  logic [7:0]          tx_q, tx_d;
  logic [RX_BITS-1:0]  rx_q, rx_d;
  logic [4:0]          bit_q, bit_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [KEY_BITS-1:0] rx_keys;

  logic gen_clr, gen_en, ph_end, phase_hi;

  assign gen_clr = (state_q == ST_IDLE) && bus.start;
  assign gen_en  = (state_q == ST_SETUP) || (state_q == ST_CMD) || (state_q == ST_READ);
  assign rx_keys = keys_from_rx(rx_q);

  tm1638_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (gen_clr),
    .en       (gen_en),
    .ph_end   (ph_end),
    .phase_hi (phase_hi)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    stb_d      = stb_q;
    sclk_d     = sclk_q;
    dio_o_d    = dio_o_q;
    dio_oe_d   = dio_oe_q;
    keys_d     = keys_q;
    key_code_d = key_code_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    wait_d     = wait_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d  = ST_SETUP;
        busy_d   = 1'b1;
        stb_d    = 1'b0;
        sclk_d   = 1'b1;
        dio_oe_d = 1'b1;
        dio_o_d  = 1'b0;
        tx_d     = CMD_READ_KEYS;
        bit_d    = '0;
      end
      ST_SETUP: if (ph_end) begin
        state_d = ST_CMD;
        sclk_d  = 1'b0;
        dio_o_d = tx_q[0];
        tx_d    = tx_q >> 1;
        bit_d   = '0;
      end
      ST_CMD: if (ph_end) begin
        if (!phase_hi) begin
          sclk_d = 1'b1;
        end else if (bit_q == CMD_LAST) begin
          // Release DIO while SCLK is high so the chip's first drive never fights us.
          state_d  = ST_WAIT;
          dio_oe_d = 1'b0;
          dio_o_d  = 1'b0;
          wait_d   = '0;
        end else begin
          sclk_d  = 1'b0;
          dio_o_d = tx_q[0];
          tx_d    = tx_q >> 1;
          bit_d   = bit_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_READ;
          sclk_d  = 1'b0;
          bit_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_READ: if (ph_end) begin
        if (!phase_hi) begin
          sclk_d = 1'b1;
          rx_d   = {bus.dio_i, rx_q[RX_BITS-1:1]};
        end else if (bit_q == RX_LAST) begin
          state_d    = ST_DONE;
          stb_d      = 1'b1;
          done_d     = 1'b1;
          keys_d     = rx_keys;
          key_code_d = key_code_f(rx_keys);
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stb_q      <= 1'b1;
      sclk_q     <= 1'b1;
      dio_o_q    <= 1'b0;
      dio_oe_q   <= 1'b0;
      keys_q     <= '0;
      key_code_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_q      <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stb_q      <= stb_d;
      sclk_q     <= sclk_d;
      dio_o_q    <= dio_o_d;
      dio_oe_q   <= dio_oe_d;
      keys_q     <= keys_d;
      key_code_q <= key_code_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_q      <= bit_d;
      wait_q     <= wait_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.stb      = stb_q;
  assign bus.sclk     = sclk_q;
  assign bus.dio_o    = dio_o_q;
  assign bus.dio_oe   = dio_oe_q;
  assign bus.keys     = keys_q;
  assign bus.key_code = key_code_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a small TM1638 model answers each scan with a
// 32-bit read pattern; table vectors plus reset-abort and back-to-back cases.
module tb_tm1638_key_reader;
  import tm1638_pkg::*;

  localparam int CD      = 2;
  localparam int WC      = 4;
  localparam int LAT     = 1 + 81 * CD + WC;
  localparam int PERIOD  = LAT + 1;
  localparam int NVEC    = 8;

  typedef struct {
    logic [31:0] rd_bits;
    logic [7:0]  exp_keys;
    logic [3:0]  exp_code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tm1638_rd_state_t dbg_state;
  tm1638_key_reader_if ifc ();

  tm1638_key_reader #(.CLK_DIV(CD), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // TM1638 model: drives the next read bit after each SCLK fall while DIO is
  // released, and captures dio_o on SCLK rises while we drive.
  logic [31:0] chip_bits = '0;
  int          rd_idx = 0;
  int          cmd_cnt = 0;
  logic [7:0]  cmd_cap = '0;
  logic        prev_stb = 1'b1;
  logic        prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (prev_stb && !ifc.stb) begin
      rd_idx  = 0;
      cmd_cnt = 0;
      cmd_cap = '0;
    end
    if (!ifc.stb && prev_sclk && !ifc.sclk && !ifc.dio_oe) begin
      ifc.dio_i = (rd_idx < 32) ? chip_bits[rd_idx] : 1'b0;
      rd_idx    = rd_idx + 1;
    end
    if (!ifc.stb && !prev_sclk && ifc.sclk && ifc.dio_oe) begin
      cmd_cap = {ifc.dio_o, cmd_cap[7:1]};
      cmd_cnt = cmd_cnt + 1;
    end
    prev_stb  = ifc.stb;
    prev_sclk = ifc.sclk;
  end

  // Done monitor: log every done-high cycle with the outputs seen then.
  int          done_n = 0;
  int          done_cyc[64];
  logic [11:0] done_val[64];

  always @(negedge clk) begin
    if (ifc.done && done_n < 64) begin
      done_cyc[done_n] = cyc;
      done_val[done_n] = {ifc.key_code, ifc.keys};
      done_n = done_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int exp_dones = 0;

  task automatic run_scan(input vec_t v, input string tag);
    int base;
    int m;
    bit seen;
    chip_bits = v.rd_bits;
    base = done_n;
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    chk({tag, ".stb_low"}, 32'(ifc.stb), 32'd0);
    chk({tag, ".busy"}, 32'(ifc.busy), 32'd1);
    seen = 1'b0;
    m = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (ifc.done) begin
        seen = 1'b1;
        m = i;
      end
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(m + 1), 32'(LAT));
    chk({tag, ".cmd_byte"}, 32'(cmd_cap), 32'(CMD_READ_KEYS));
    chk({tag, ".cmd_bits"}, 32'(cmd_cnt), 32'd8);
    chk({tag, ".keys"}, 32'(ifc.keys), 32'(v.exp_keys));
    chk({tag, ".key_code"}, 32'(ifc.key_code), 32'(v.exp_code));
    exp_dones = exp_dones + 1;
    @(posedge clk); #1;
    chk({tag, ".done_width"}, 32'(ifc.done), 32'd0);
    chk({tag, ".busy_drop"}, 32'(ifc.busy), 32'd0);
    chk({tag, ".done_count"}, 32'(done_n - base), 32'd1);
  endtask

  vec_t vecs[NVEC];
  vec_t v;

  initial begin
    int base;
    int dn;
    bit ok;
    ifc.start = 1'b0;
    ifc.dio_i = 1'b0;

    // Bytes are packed byte0 in [7:0] .. byte3 in [31:24].
    vecs[0] = '{32'h00_00_00_01, 8'h01, 4'd1};
    vecs[1] = '{32'h01_00_10_00, 8'h28, 4'd4};
    vecs[2] = '{32'hEF_EE_FE_EE, 8'h28, 4'd4};
    vecs[3] = '{32'h00_00_00_00, 8'h00, 4'd0};
    vecs[4] = '{32'h10_00_00_00, 8'h80, 4'd8};
    vecs[5] = '{32'h00_01_00_00, 8'h04, 4'd3};
    vecs[6] = '{32'h10_10_10_10, 8'hF0, 4'd5};
    vecs[7] = '{32'hFF_FF_FF_FF, 8'hFF, 4'd1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no start.
    repeat (50) @(posedge clk);
    #1;
    chk("idle.stb", 32'(ifc.stb), 32'd1);
    chk("idle.sclk", 32'(ifc.sclk), 32'd1);
    chk("idle.dio_oe", 32'(ifc.dio_oe), 32'd0);
    chk("idle.dio_o", 32'(ifc.dio_o), 32'd0);
    chk("idle.busy", 32'(ifc.busy), 32'd0);
    chk("idle.keys", 32'(ifc.keys), 32'd0);
    chk("idle.key_code", 32'(ifc.key_code), 32'd0);
    chk("idle.no_done", 32'(done_n), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_scan(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of READ bit 12 aborts with reset values, no done.
    chip_bits = 32'hFFFF_FFFF;
    base = done_n;
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (rd_idx == 13) ok = 1'b1;
    end
    chk("abort.reach_bit12", 32'(ok), 32'd1);
    chk("abort.state_read", 32'(dbg_state), 32'(ST_READ));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.stb", 32'(ifc.stb), 32'd1);
    chk("abort.sclk", 32'(ifc.sclk), 32'd1);
    chk("abort.busy", 32'(ifc.busy), 32'd0);
    chk("abort.dio_oe", 32'(ifc.dio_oe), 32'd0);
    chk("abort.keys", 32'(ifc.keys), 32'd0);
    chk("abort.key_code", 32'(ifc.key_code), 32'd0);
    chk("abort.done", 32'(ifc.done), 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("abort.no_done", 32'(done_n - base), 32'd0);
    v = '{32'h00_00_10_00, 8'h20, 4'd6};
    run_scan(v, "post_abort");

    // start held high: back-to-back scans with a one-cycle idle gap.
    chip_bits = 32'h00_10_00_00;
    base = done_n;
    @(posedge clk); #1 ifc.start = 1'b1;
    dn = 0;
    for (int i = 0; i < 4 * PERIOD && dn < 3; i++) begin
      @(posedge clk); #1;
      if (ifc.done) dn = dn + 1;
    end
    ifc.start = 1'b0;
    chk("b2b.done_seen", 32'(dn), 32'd3);
    exp_dones = exp_dones + 3;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b.busy_after", 32'(ifc.busy), 32'd0);
    chk("b2b.done_count", 32'(done_n - base), 32'd3);
    if (done_n - base >= 3) begin
      chk("b2b.period1", 32'(done_cyc[base + 1] - done_cyc[base]), 32'(PERIOD));
      chk("b2b.period2", 32'(done_cyc[base + 2] - done_cyc[base + 1]), 32'(PERIOD));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b.out%0d", i), 32'(done_val[base + i]), 32'({4'd7, 8'h40}));
      end
    end

    chk("total_dones", 32'(done_n), 32'(exp_dones));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_key_reader.md
# tm1638_key_reader

Reads the TM1638 key-scan matrix over its 3-wire serial bus (STB/CLK/DIO) and delivers an 8-bit pressed-key mask plus a 4-bit key number. It is the input-side counterpart of the segment/digit write path to the same TM1638 board. It sits between the board pins and user logic, and shares STB/CLK/DIO with the display writer through an external arbiter. `key_code` is directly usable as a digit value on the 4-bit digit-to-segment path.

## Interface
- `CLK_DIV`, default 50: system clocks per SCLK half-period; must be ≥1. 50 gives 1 MHz SCLK at 100 MHz.
- `WAIT_CYCLES`, default 100: clocks between command and first read bit (TM1638 Twait ≥1 µs); must be ≥1.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request one key scan; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse; `keys`/`key_code` are updated in the same cycle.
- `stb` out 1: TM1638 STB, active low.
- `sclk` out 1: TM1638 CLK, idle high.
- `dio_o` out 1: DIO output data.
- `dio_oe` out 1: DIO output enable; the pad tristate is external.
- `dio_i` in 1: DIO input, already synchronised externally.
- `keys` out 8: pressed mask; bit i = button S(i+1).
- `key_code` out 4: 1..8 = lowest-numbered pressed button; 0 = none.

## Operation
- Reset values: `busy`=0, `done`=0, `stb`=1, `sclk`=1, `dio_o`=0, `dio_oe`=0, `keys`=0, `key_code`=0. Reset mid-scan aborts the scan immediately with these values; no `done` is issued.
- FSM states: IDLE → SETUP → CMD → WAIT → READ → DONE → IDLE.
- IDLE: `start`=1 moves to SETUP. `start` is ignored in all other states.
- SETUP: `stb`=0, `sclk`=1, `dio_oe`=1; lasts CLK_DIV cycles.
- CMD: shifts out 8'h42, LSB first. Each bit:
  - low phase of CLK_DIV cycles with `sclk`=0 and `dio_o`=bit, set on entry to the phase;
  - high phase of CLK_DIV cycles.
- WAIT: `dio_oe`=0, `sclk`=1, `stb`=0; lasts WAIT_CYCLES cycles.
- READ: 32 bits, LSB first: bytes 0..3, each LSB first.
  - Low and high phases are as in CMD, with `dio_oe`=0.
  - `dio_i` is sampled in the last cycle of each low phase, i.e. the cycle in which `sclk` is driven 0→1.
- Key mapping: `keys[b]` = byte b bit 0 and `keys[b+4]` = byte b bit 4, for b = 0..3. All other read bits are discarded.
- DONE (one cycle): `stb`=1, `sclk`=1, `done`=1, `keys`/`key_code` loaded; next state IDLE.
- `key_code`: priority encode, lowest set index i gives i+1; mask 0 gives 0.
- `keys` and `key_code` hold their value between scans.

## Timing
- `start` accepted at edge k: `stb`=0 and `busy`=1 from cycle k+1.
- Phase lengths:
  - SETUP: CLK_DIV cycles.
  - CMD: 16·CLK_DIV cycles.
  - WAIT: WAIT_CYCLES cycles.
  - READ: 64·CLK_DIV cycles.
- `done` is asserted at cycle k+1+81·CLK_DIV+WAIT_CYCLES. `busy` drops the following cycle. A new `start` in that cycle is accepted.
- First SCLK falling edge occurs CLK_DIV cycles after STB falls. STB rises 0 cycles after the last SCLK high phase ends.
- `dio_oe` falls in the first WAIT cycle, with `sclk` high, so there is no bus contention on the chip's first drive.

## Structure
- `tm1638_pkg` holds:
  - `CMD_READ_KEYS` = 8'h42;
  - state enum `tm1638_rd_state_t`;
  - `KEY_BYTES` = 4 and `KEY_BITS` = 8 constants.
  - The display writer shares the command constants.
- Sub-module `tm1638_sclk_gen`: CLK_DIV phase counter. It outputs a `ph_end` strobe and a phase flag, and is reusable by the writer.
- The FSM, 8-bit TX shift, 32-bit RX shift, bit counter (0..31) and priority encoder live in the top module.

## Test plan
Settings: CLK_DIV=2, WAIT_CYCLES=4. The bench models the TM1638 and drives `dio_i` after each SCLK fall.
1. Idle after reset, no `start` for 50 cycles → `stb`=1, `sclk`=1, `dio_oe`=0, `keys`=0, `key_code`=0, no `done`.
2. `start`, chip returns bytes 01,00,00,00 → bus shows 0x42 LSB-first on `dio_o`; `done` exactly 167 cycles after the start cycle; `keys`=8'h01, `key_code`=1.
3. Chip returns 00,10,00,01 → `keys`=8'h28, `key_code`=4. Also check non-key bits 0xEE in every byte → ignored (`keys` unchanged by them).
4. All bytes 00 → `keys`=0, `key_code`=0, `done` pulse still one cycle.
5. `rst` asserted during READ bit 12 → next cycle `stb`=1, `busy`=0, `keys`=0; no `done`. The next `start` completes normally.
6. `start` held high continuously → back-to-back scans, each 167 cycles long with a `done` pulse. `start` pulses during `busy` do not lengthen or restart a scan.
